framebuffer_write_arbiter: RTL and testbench

Single-clock write-side controller for the 160x120 QQVGA framebuffer. It shares the framebuffer write port between two pixel requesters using round-robin arbitration and valid/ready handshakes, and it also runs a full-screen clear sequencer. It converts (x, y) coordinates to linear addresses and drives the framebuffer's `write_addr`/`data`/`we` inputs from registers. It sits in the write-clock domain in front of the dual-port framebuffer.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_xy_to_addr.sv | 23 ++
 rtl/framebuffer_write_arbiter.sv | 114 +++++++++++
 tb/tb_framebuffer_write_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the QQVGA framebuffer write and read sides.
package fb_pkg;

  localparam int H_RES     = 160;
  localparam int V_RES     = 120;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int X_WIDTH   = 8;
  localparam int Y_WIDTH   = 7;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_xy_to_addr.sv
// Combinational (x, y) to linear framebuffer address, plus an in-range flag.
module fb_xy_to_addr #(
  parameter int ADDR_WIDTH = 15,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120
) (
  input  logic [fb_pkg::X_WIDTH-1:0] x,
  input  logic [fb_pkg::Y_WIDTH-1:0] y,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic                       in_range
);
  import fb_pkg::*;

  // y*160 as two shifts; 15 bits holds the worst case even for out-of-range inputs
  logic [14:0] sum;

  always_comb begin
    sum      = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
    addr     = ADDR_WIDTH'(sum);
    in_range = (32'(x) < H_RES) && (32'(y) < V_RES);
  end

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Write-side framebuffer controller: round-robin arbitration of two pixel requesters
// and a full-screen clear sequencer, driving registered write address/data/enable.
module framebuffer_write_arbiter #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 15,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  req0_valid,
  input  logic [7:0]            req0_x,
  input  logic [6:0]            req0_y,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [7:0]            req1_x,
  input  logic [6:0]            req1_y,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [ADDR_WIDTH-1:0] fb_write_addr,
  output logic [DATA_WIDTH-1:0] fb_data,
  output logic                  fb_we
);
  import fb_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);

  fb_state_t             state;
  logic [ADDR_WIDTH-1:0] clear_cnt;
  logic                  last_grant;
  logic                  grant;
  logic                  handshake;
  logic [7:0]            sel_x;
  logic [6:0]            sel_y;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_in_range;

  // Contention goes to whoever did not win the last completed handshake
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == SERVE) && req0_valid && !grant;
  assign req1_ready = (state == SERVE) && req1_valid && grant;
  assign handshake  = req0_ready || req1_ready;
  assign clear_busy = (state == CLEAR);

  assign sel_x    = req1_ready ? req1_x    : req0_x;
  assign sel_y    = req1_ready ? req1_y    : req0_y;
  assign sel_data = req1_ready ? req1_data : req0_data;

  fb_xy_to_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .H_RES      (H_RES),
    .V_RES      (V_RES)
  ) u_xy_to_addr (
    .x        (sel_x),
    .y        (sel_y),
    .addr     (sel_addr),
    .in_range (sel_in_range)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= SERVE;
      clear_cnt     <= '0;
      last_grant    <= 1'b1;
      fb_we         <= 1'b0;
      fb_write_addr <= '0;
      fb_data       <= '0;
      clear_done    <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        SERVE: begin
          if (handshake) begin
            last_grant <= req1_ready;
            // Out-of-range pixels complete the handshake but are dropped
            if (sel_in_range) begin
              fb_we         <= 1'b1;
              fb_write_addr <= sel_addr;
              fb_data       <= sel_data;
            end
          end
          if (clear_start) begin
            state     <= CLEAR;
            clear_cnt <= '0;
          end
        end
        CLEAR: begin
          fb_we         <= 1'b1;
          fb_write_addr <= clear_cnt;
          fb_data       <= clear_color;
          clear_cnt     <= clear_cnt + 1'b1;
          if (clear_cnt == LAST_ADDR) begin
            clear_done <= 1'b1;
            state      <= SERVE;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Scoreboard bench for framebuffer_write_arbiter: arbitration, address mapping,
// out-of-range drop, clear sequencing and reset during clear.
module tb_framebuffer_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_start = 1'b0;
  logic [0:0]  clear_color = 1'b0;
  logic        clear_busy, clear_done;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_x = '0, req1_x = '0;
  logic [6:0]  req0_y = '0, req1_y = '0;
  logic [0:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic [14:0] fb_write_addr;
  logic [0:0]  fb_data;
  logic        fb_we;

  typedef struct {
    logic [14:0] addr;
    logic        data;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic model_last = 1'b1;

  framebuffer_write_arbiter #(
    .DATA_WIDTH (1),
    .ADDR_WIDTH (15),
    .H_RES      (160),
    .V_RES      (120)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clear_start   (clear_start),
    .clear_color   (clear_color),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .req0_valid    (req0_valid),
    .req0_x        (req0_x),
    .req0_y        (req0_y),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_x        (req1_x),
    .req1_y        (req1_y),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .fb_write_addr (fb_write_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we)
  );

  always #5 clock = ~clock;

  // Write monitor: every framebuffer write must match the head of the scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (fb_we !== 1'b0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d data=%0d, no write expected", fb_write_addr, fb_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (fb_write_addr !== e.addr || fb_data !== e.data || clear_done !== e.done) begin
            n_fail++;
            $display("FAIL write: got addr=%0d data=%0d done=%0d, expected addr=%0d data=%0d done=%0d",
                     fb_write_addr, fb_data, clear_done, e.addr, e.data, e.done);
          end
        end
      end else begin
        n_cmp++;
        if (clear_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_without_write: clear_done=%0d, expected 0", clear_done);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_pixel(input int x, input int y, input logic d);
    exp_t e;
    e.addr = 15'(y * 160 + x);
    e.data = d;
    e.done = 1'b0;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clock);
    n_cmp++;
    if (fb_we !== 1'b0 || fb_write_addr !== 15'd0 || fb_data !== 1'b0 ||
        clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: we=%0d addr=%0d data=%0d busy=%0d done=%0d, expected all 0",
               fb_we, fb_write_addr, fb_data, clear_busy, clear_done);
    end
    step();
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_x = 8'd3; req0_y = 7'd2; req0_data = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: ready0=%0d ready1=%0d, expected 1 0", req0_ready, req1_ready);
    end
    push_pixel(3, 2, 1'b1);
    model_last = 1'b0;
    step();
    req0_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (fb_we !== 1'b1 || fb_write_addr !== 15'd323) begin
      n_fail++;
      $display("FAIL single_write: we=%0d addr=%0d, expected 1 323", fb_we, fb_write_addr);
    end
    step();
  endtask

  task automatic test_round_robin();
    int   i0 = 0, i1 = 0;
    logic g;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_last = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req0_x = 8'(i0 * 2);     req0_y = 7'd10; req0_data = 1'(i0);
      req1_x = 8'(i1 * 2 + 1); req1_y = 7'd10; req1_data = 1'(i1 + 1);
      @(negedge clock);
      g = ~model_last;
      n_cmp++;
      if (req0_ready !== !g || req1_ready !== g) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ready0=%0d ready1=%0d, expected grant to %0d", c, req0_ready, req1_ready, g);
      end
      if (g) begin
        push_pixel(i1 * 2 + 1, 10, 1'(i1 + 1));
        i1++;
      end else begin
        push_pixel(i0 * 2, 10, 1'(i0));
        i0++;
      end
      model_last = g;
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_out_of_range();
    req1_valid = 1'b1; req1_x = 8'd160; req1_y = 7'd0; req1_data = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_ready: ready1=%0d, expected 1", req1_ready);
    end
    model_last = 1'b1;
    step();
    req1_x = 8'd159; req1_y = 7'd119; req1_data = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (fb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_dropped: we=%0d, expected 0", fb_we);
    end
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL corner_ready: ready1=%0d, expected 1", req1_ready);
    end
    push_pixel(159, 119, 1'b1);
    step();
    req1_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (fb_write_addr !== 15'd19199) begin
      n_fail++;
      $display("FAIL corner_addr: addr=%0d, expected 19199", fb_write_addr);
    end
    step();
  endtask

  task automatic test_clear();
    int   busy = 0;
    bit   ended = 0;
    exp_t e;
    req0_valid = 1'b1; req0_x = 8'd5; req0_y = 7'd1; req0_data = 1'b0;
    clear_start = 1'b1; clear_color = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_concurrent_ready: ready0=%0d, expected 1", req0_ready);
    end
    push_pixel(5, 1, 1'b0);
    model_last = 1'b0;
    for (int k = 0; k < 19200; k++) begin
      e.addr = 15'(k);
      e.data = 1'b1;
      e.done = (k == 19199);
      sb.push_back(e);
    end
    step();
    clear_start = 1'b0;
    req0_x = 8'd7; req0_y = 7'd1; req0_data = 1'b1;
    req1_valid = 1'b1; req1_x = 8'd8; req1_y = 7'd1; req1_data = 1'b0;
    for (int c = 0; c < 20000 && !ended; c++) begin
      @(negedge clock);
      if (clear_busy === 1'b1) begin
        busy++;
        if (busy == 100) clear_start = 1'b1;
        if (busy == 101) clear_start = 1'b0;
        n_cmp++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_ready: ready0=%0d ready1=%0d at busy cycle %0d, expected 0 0",
                   req0_ready, req1_ready, busy);
        end
      end else begin
        ended = 1;
        n_cmp++;
        if (busy != 19200) begin
          n_fail++;
          $display("FAIL clear_length: busy cycles=%0d, expected 19200", busy);
        end
        n_cmp++;
        if (clear_done !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_done_pulse: clear_done=%0d, expected 1", clear_done);
        end
        n_cmp++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL post_clear_grant: ready0=%0d ready1=%0d, expected 0 1", req0_ready, req1_ready);
        end
        push_pixel(8, 1, 1'b0);
        model_last = 1'b1;
      end
    end
    if (!ended) begin
      n_cmp++;
      n_fail++;
      $display("FAIL clear_timeout: busy cycles=%0d, expected clear to end after 19200", busy);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    bit   hit = 0;
    clear_start = 1'b1; clear_color = 1'b0;
    for (int k = 0; k <= 5000; k++) begin
      e.addr = 15'(k);
      e.data = 1'b0;
      e.done = 1'b0;
      sb.push_back(e);
    end
    step();
    clear_start = 1'b0;
    for (int c = 0; c < 6000 && !hit; c++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) hit = 1;
    end
    if (!hit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL mid_clear_timeout: %0d writes still pending, expected 0", sb.size());
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_last = 1'b1;
    req0_valid = 1'b1; req0_x = 8'd1; req0_y = 7'd0; req0_data = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (fb_we !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: we=%0d busy=%0d done=%0d, expected 0 0 0", fb_we, clear_busy, clear_done);
    end
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_ready: ready0=%0d, expected 1", req0_ready);
    end
    push_pixel(1, 0, 1'b1);
    step();
    req0_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected writes never seen, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
